// File: rtl/audio_sample_pwm.sv
// -----------------------------------------------------------------------------
// audio_sample_pwm
//
// Downstream consumer of the audio_out register block. Samples handed over on
// the s_t* handshake are queued in a small FIFO and replayed one per
// SAMPLE_DIV clock cycles. The current sample drives a single-bit PWM stream
// for the mono amplifier, and audio_sd follows the playback enable.
//
// Handshake: a sample transfers on any rising ACLK edge where s_tvalid and
// s_tready are both high. s_tready is low during reset and for the first cycle
// after release, then tracks "FIFO not full". While s_tvalid is high and
// s_tready low, the producer holds s_tdata stable.
//
// Ports
//   ACLK          in   1        clock, rising edge
//   ARESET        in   1        asynchronous active-high reset
//   enable        in   1        playback enable
//   s_tdata       in   DATA_W   signed PCM sample
//   s_tvalid      in   1        sample valid
//   s_tready      out  1        FIFO can accept a sample
//   clr_underrun  in   1        pulse, clears the underrun flag
//   sample_tick   out  1        one-cycle pulse at each sample boundary
//   fifo_level    out  LVL_W    entries currently held
//   underrun      out  1        sticky: a tick found the FIFO empty
//   pwm_out       out  1        registered PWM audio bit
//   audio_sd      out  1        registered amplifier enable (1 = on)
// -----------------------------------------------------------------------------
module audio_sample_pwm #(
    parameter int DATA_W     = 16,
    parameter int PWM_BITS   = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_DIV = 2268,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1,
    localparam int DIV_W     = $clog2(SAMPLE_DIV)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              clr_underrun,
    output logic              sample_tick,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              underrun,
    output logic              pwm_out,
    output logic              audio_sd
);

    // Sample storage; contents need no reset because the pointers and level
    // define what is valid.
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]    level_q,    level_d;
    logic [DIV_W-1:0]    div_cnt_q,  div_cnt_d;
    logic [DATA_W-1:0]   cur_q,      cur_d;
    logic                underrun_q, underrun_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic                pwm_q,      pwm_d;
    logic                sd_q,       sd_d;
    // Goes high on the first edge after reset release so s_tready stays low
    // for one cycle after reset.
    logic                rdy_en_q,   rdy_en_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                tick;
    logic                push;
    logic                pop;
    logic [PWM_BITS-1:0] duty;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign tick       = enable && (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
    assign push       = s_tvalid && s_tready;
    // Emptiness is judged on the registered level, so a push landing on the
    // tick cycle cannot be consumed by that tick.
    assign pop        = tick && !fifo_empty;

    // Offset binary: flip the sign bit so the most negative sample maps to 0
    // and the most positive to full scale.
    assign duty = {~cur_q[DATA_W-1], cur_q[DATA_W-2 -: PWM_BITS-1]};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        div_cnt_d  = div_cnt_q;
        cur_d      = cur_q;
        underrun_d = underrun_q;
        pwm_cnt_d  = pwm_cnt_q;
        pwm_d      = 1'b0;
        sd_d       = enable;
        rdy_en_d   = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (!enable) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // An empty tick plays midscale (zero) and flags the underrun; the
        // set takes priority over a coincident clear.
        if (tick) begin
            cur_d = fifo_empty ? '0 : mem_q[rd_ptr_q];
        end
        if (tick && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end

        pwm_cnt_d = enable ? pwm_cnt_q + PWM_BITS'(1) : '0;
        pwm_d     = enable && (pwm_cnt_q < duty);
    end

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_tdata;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            div_cnt_q  <= '0;
            cur_q      <= '0;
            underrun_q <= 1'b0;
            pwm_cnt_q  <= '0;
            pwm_q      <= 1'b0;
            sd_q       <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            div_cnt_q  <= div_cnt_d;
            cur_q      <= cur_d;
            underrun_q <= underrun_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_q      <= pwm_d;
            sd_q       <= sd_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    assign s_tready    = rdy_en_q && !fifo_full;
    assign sample_tick = tick;
    assign fifo_level  = level_q;
    assign underrun    = underrun_q;
    assign pwm_out     = pwm_q;
    assign audio_sd    = sd_q;

endmodule

// File: tb/tb_audio_sample_pwm.sv
module tb_audio_sample_pwm;

    localparam int DATA_W     = 16;
    localparam int PWM_BITS   = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int SAMPLE_DIV = 64;
    localparam int LVL_W      = 4;
    localparam int PERIOD     = 1 << PWM_BITS;

    // ---------------- clock / reset / DUT ----------------
    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              enable = 1'b0;
    logic [DATA_W-1:0] s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic              clr_underrun = 1'b0;
    logic              sample_tick;
    logic [LVL_W-1:0]  fifo_level;
    logic              underrun;
    logic              pwm_out;
    logic              audio_sd;

    always #5 ACLK = ~ACLK;

    audio_sample_pwm #(
        .DATA_W(DATA_W), .PWM_BITS(PWM_BITS),
        .FIFO_DEPTH(FIFO_DEPTH), .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .clr_underrun(clr_underrun), .sample_tick(sample_tick),
        .fifo_level(fifo_level), .underrun(underrun),
        .pwm_out(pwm_out), .audio_sd(audio_sd)
    );

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_fails  = 0;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_q[$];      // samples waiting, oldest first
    logic [DATA_W-1:0] m_cur;       // sample being played
    bit                m_underrun;
    bit                m_pwm;       // expected pwm_out for the coming cycle
    bit                m_sd;
    bit                m_ready_ok;  // a clock edge has passed since reset
    int                m_en_cycles; // consecutive enabled cycles so far
    bit                last_tick;
    bit                last_accept;
    int                pwm_high_cnt;

    function automatic int duty_of(input logic [DATA_W-1:0] s);
        // Shift the signed range to 0..65535 and keep the top PWM_BITS bits.
        return (int'($signed(s)) + 32768) >> (DATA_W - PWM_BITS);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cur       = '0;
        m_underrun  = 1'b0;
        m_pwm       = 1'b0;
        m_sd        = 1'b0;
        m_ready_ok  = 1'b0;
        m_en_cycles = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare all outputs at the falling edge, advance the
    // model using the inputs of that cycle, return 1 time unit after the
    // following rising edge.
    task automatic step();
        bit tick, rdy, push, was_empty;
        int duty;
        @(negedge ACLK);
        if (ARESET) begin
            model_reset();
            rdy  = 1'b0;
            tick = 1'b0;
        end else begin
            rdy  = m_ready_ok && (m_q.size() < FIFO_DEPTH);
            tick = enable && (m_en_cycles % SAMPLE_DIV == SAMPLE_DIV - 1);
        end
        check("s_tready",    32'(s_tready),    32'(rdy));
        check("sample_tick", 32'(sample_tick), 32'(tick));
        check("fifo_level",  32'(fifo_level),  32'(m_q.size()));
        check("underrun",    32'(underrun),    32'(m_underrun));
        check("pwm_out",     32'(pwm_out),     32'(m_pwm));
        check("audio_sd",    32'(audio_sd),    32'(m_sd));
        if (pwm_out === 1'b1) pwm_high_cnt++;
        last_tick   = tick;
        last_accept = s_tvalid && rdy;
        if (!ARESET) begin
            push      = s_tvalid && rdy;
            was_empty = (m_q.size() == 0);
            duty      = duty_of(m_cur);
            m_pwm     = enable && ((m_en_cycles % PERIOD) < duty);
            m_sd      = enable;
            if (tick) m_cur = was_empty ? '0 : m_q.pop_front();
            if (tick && was_empty) m_underrun = 1'b1;
            else if (clr_underrun) m_underrun = 1'b0;
            if (push) m_q.push_back(s_tdata);
            m_en_cycles = enable ? m_en_cycles + 1 : 0;
            m_ready_ok  = 1'b1;
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fails++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    // Step until a tick cycle has been checked.
    task automatic wait_tick();
        int k = 0;
        do begin
            step();
            k++;
        end while (!last_tick && k < 4 * SAMPLE_DIV);
        if (!last_tick) timeout("wait_tick");
    endtask

    // Step until the coming cycle is a tick cycle.
    task automatic to_pre_tick();
        int k = 0;
        while (!(enable && (m_en_cycles % SAMPLE_DIV == SAMPLE_DIV - 1)) && k < 4 * SAMPLE_DIV) begin
            step();
            k++;
        end
        if (k >= 4 * SAMPLE_DIV) timeout("to_pre_tick");
    endtask

    // Called right after a tick cycle: skip the cur-register cycle, then count
    // pwm_out highs across one full PWM period.
    task automatic measure_after_tick(input string tag, input int exp_high);
        step();
        pwm_high_cnt = 0;
        repeat (PERIOD) step();
        check(tag, 32'(pwm_high_cnt), 32'(exp_high));
    endtask

    task automatic push_one(input logic [DATA_W-1:0] d);
        int k = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        do begin
            step();
            k++;
        end while (!last_accept && k < 4 * SAMPLE_DIV);
        if (!last_accept) timeout("push_one");
        s_tvalid = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int rate;
        model_reset();

        // 1: reset, then release
        repeat (3) step();
        ARESET = 1'b0;
        step();
        check("ready_after_release", 32'(s_tready), 32'd1);

        // 2: enable low, nine back-to-back pushes
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push_one(16'($urandom));
        check("level_full", 32'(fifo_level), 32'd8);
        check("ready_full", 32'(s_tready), 32'd0);
        s_tvalid = 1'b1;
        s_tdata  = 16'($urandom);
        repeat (5) step();
        check("ninth_held", 32'(last_accept), 32'd0);
        // enabling frees a slot at the first tick and the held 9th goes in
        enable = 1'b1;
        begin
            int k = 0;
            do begin
                step();
                k++;
            end while (!last_accept && k < 4 * SAMPLE_DIV);
            if (!last_accept) timeout("ninth_accept");
        end
        s_tvalid = 1'b0;
        check("level_after_ninth", 32'(fifo_level), 32'd8);
        // drain all eight, then one empty tick
        repeat (9) wait_tick();
        step();
        check("underrun_after_drain", 32'(underrun), 32'd1);
        enable = 1'b0;
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("underrun_cleared", 32'(underrun), 32'd0);

        // 3: full scale, midscale, negative full scale in push order
        push_one(16'h7FFF);
        push_one(16'h0000);
        push_one(16'h8000);
        enable = 1'b1;
        wait_tick();
        measure_after_tick("duty_7fff", 15);
        wait_tick();
        measure_after_tick("duty_0000", 8);
        wait_tick();
        measure_after_tick("duty_8000", 0);

        // 4: empty FIFO while enabled
        wait_tick();
        check("underrun_set", 32'(underrun), 32'd1);
        measure_after_tick("duty_underrun", 8);
        to_pre_tick();
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("set_wins_over_clear", 32'(underrun), 32'd1);
        step();
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("lone_clear", 32'(underrun), 32'd0);

        // 5: push lands on a tick with level 3
        push_one(16'h1000);
        push_one(16'h3000);
        push_one(16'h5000);
        to_pre_tick();
        s_tvalid = 1'b1;
        s_tdata  = 16'h7000;
        step();
        s_tvalid = 1'b0;
        check("push_pop_accept", 32'(last_accept), 32'd1);
        check("push_pop_level", 32'(fifo_level), 32'd3);
        measure_after_tick("oldest_popped", 9);

        // 6: asynchronous reset mid-playback with level 5
        push_one(16'h2000);
        push_one(16'h6000);
        check("level_five", 32'(fifo_level), 32'd5);
        for (int k = 0; k < 2 * PERIOD && !m_pwm; k++) step();
        check("pwm_high_before_reset", 32'(pwm_out), 32'd1);
        #2;
        ARESET = 1'b1;
        #1;
        check("async_pwm",   32'(pwm_out),    32'd0);
        check("async_sd",    32'(audio_sd),   32'd0);
        check("async_level", 32'(fifo_level), 32'd0);
        model_reset();
        repeat (2) step();
        ARESET = 1'b0;
        push_one(16'h7FFF);
        wait_tick();
        measure_after_tick("after_reset_sample", 15);

        // random traffic against the model
        rate = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) rate = $urandom_range(2, 90);
            if (!(s_tvalid && !last_accept)) begin
                s_tvalid = ($urandom_range(0, rate - 1) == 0);
                s_tdata  = 16'($urandom);
            end
            if ($urandom_range(0, 599) == 0) enable = ~enable;
            clr_underrun = ($urandom_range(0, 149) == 0);
            step();
        end
        s_tvalid = 1'b0;
        clr_underrun = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
